// File: rtl/dmem_req_queue_pkg.sv
// dmem_req_queue_pkg: shared types and defaults for the data-memory request queue
package dmem_req_queue_pkg;
  localparam int dmem_max_out_gp = 4;
  localparam int rd_size_gp = 5;
  typedef enum logic {CMD_IDLE, CMD_SENT} dmem_cmd_e;
  typedef struct packed {
    logic [rd_size_gp-1:0] rd;
    logic                  is_byte;
    logic [1:0]            byte_sel;
  } ld_tag_s;
endpackage

// File: rtl/dmem_tag_fifo.sv
// dmem_tag_fifo: power-of-two depth tag FIFO with occupancy count; caller guards push/pop
module dmem_tag_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/dmem_req_queue.sv
// dmem_req_queue: pipelined data-memory command issue with in-order load return tags
// Define DMEM_MISALIGN_TRAP_EN to drop misaligned word requests and flag err_o.
module dmem_req_queue
  import dmem_req_queue_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int RD_W    = 5,
  parameter int MAX_OUT = dmem_max_out_gp
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wen_i,
  input  logic              req_byte_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [RD_W-1:0]   req_rd_i,
  output logic              mem_valid_o,
  output logic              mem_wen_o,
  output logic              mem_byte_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_yumi_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_yumi_o,
  output logic              ld_valid_o,
  output logic [RD_W-1:0]   ld_rd_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              busy_o,
  output logic              err_o
);
  localparam int TAG_W = RD_W + 3;
  localparam int CNT_W = $clog2(MAX_OUT) + 1;
  dmem_cmd_e state, state_n;
  logic [CNT_W-1:0] count;
  logic [TAG_W-1:0] head;
  logic [RD_W-1:0] head_rd;
  logic head_byte;
  logic [1:0] head_sel;
  logic full, empty, pop, push, acc, issue, trap;
  assign {head_rd, head_byte, head_sel} = head;
  assign full = count == CNT_W'(MAX_OUT);
  assign empty = count == '0;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = !req_byte_i & |req_addr_i[1:0];
`else
  assign trap = 1'b0;
`endif
  assign pop = mem_rvalid_i & !empty;
  assign mem_yumi_o = pop;
  // a full FIFO still takes a new load when a response frees a slot this cycle
  assign req_ready_o = (state == CMD_IDLE | mem_yumi_i) & !(!req_wen_i & !trap & full & !pop);
  assign acc = req_valid_i & req_ready_o;
  assign issue = acc & !trap;
  assign push = issue & !req_wen_i;
  assign mem_valid_o = state == CMD_SENT;
  assign busy_o = state != CMD_IDLE | !empty;
  always_comb state_n = issue ? CMD_SENT : (mem_yumi_i ? CMD_IDLE : state);
  dmem_tag_fifo #(.W(TAG_W), .DEPTH(MAX_OUT)) tags (
    .clk(clk),
    .n_reset(n_reset),
    .push(push),
    .pop(pop),
    .din({req_rd_i, req_byte_i, req_addr_i[1:0]}),
    .dout(head),
    .count(count)
  );
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state       <= CMD_IDLE;
      mem_wen_o   <= 1'b0;
      mem_byte_o  <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      ld_valid_o  <= 1'b0;
      ld_rd_o     <= '0;
      ld_data_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      state <= state_n;
      if (issue) begin
        mem_wen_o   <= req_wen_i;
        mem_byte_o  <= req_byte_i;
        mem_addr_o  <= req_byte_i ? req_addr_i : {req_addr_i[ADDR_W-1:2], 2'b00};
        mem_wdata_o <= req_byte_i ? {(DATA_W/8){req_wdata_i[7:0]}} : req_wdata_i;
      end
      ld_valid_o <= pop;
      if (pop) begin
        ld_rd_o   <= head_rd;
        ld_data_o <= head_byte ? {{(DATA_W-8){1'b0}}, mem_rdata_i[{head_sel, 3'b000} +: 8]} : mem_rdata_i;
      end
      if ((mem_rvalid_i & empty) | (acc & trap)) err_o <= 1'b1;
    end
endmodule

// File: doc/dmem_req_queue.md
Name: dmem_req_queue

Overview:
Parametrised successor to the single-request data-memory handshake (DMEM_IDLE / DMEM_REQ_SENT / DMEM_REQ_ACKED). It sits between the core's memory stage and data memory. It issues word and byte loads and stores, and keeps up to MAX_OUT loads outstanding in a tag FIFO. It returns load data in order, with the destination register index, so the pipeline stalls only when the queue is full rather than on every access.

Parameters:
DATA_W, 32, data word width; must be a multiple of 8.
ADDR_W, 12, byte-address width (data_mem_addr_width_gp).
RD_W, 5, destination register index width (rd_size_gp).
MAX_OUT, 4, maximum outstanding loads; power of 2, at least 2.

Ports:
clk  in  1  clock
n_reset  in  1  asynchronous active-low reset
req_valid_i  in  1  memory stage presents a request
req_ready_o  out  1  request accepted this cycle when high together with req_valid_i
req_wen_i  in  1  1 = store, 0 = load
req_byte_i  in  1  byte operation (LBU/SB)
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  DATA_W  store data; low byte is used for SB
req_rd_i  in  RD_W  load destination register
mem_valid_o  out  1  command valid to memory
mem_wen_o  out  1  command write enable
mem_byte_o  out  1  command byte_not_word
mem_addr_o  out  ADDR_W  command address
mem_wdata_o  out  DATA_W  command write data
mem_yumi_i  in  1  memory accepted the command
mem_rvalid_i  in  1  memory returns load data
mem_rdata_i  in  DATA_W  returned word
mem_yumi_o  out  1  response consumed; equals mem_rvalid_i whenever the FIFO is non-empty
ld_valid_o  out  1  load result valid, one-cycle pulse
ld_rd_o  out  RD_W  destination register of the result
ld_data_o  out  DATA_W  result; byte loads are zero-extended
busy_o  out  1  command pending or loads outstanding
err_o  out  1  sticky error flag

Behaviour:
- Reset (async, n_reset=0): command state CMD_IDLE; tag FIFO empty (rd_ptr=wr_ptr=0, count=0); all outputs 0 except req_ready_o=1.
- Command FSM (dmem_cmd_e):
  - CMD_IDLE: on req_valid_i & req_ready_o, register the command and go to CMD_SENT.
  - CMD_SENT: mem_valid_o=1 with the registered fields. On mem_yumi_i: if a new request is accepted the same cycle, stay in CMD_SENT with the new command; otherwise return to CMD_IDLE.
- req_ready_o = (state==CMD_IDLE | mem_yumi_i) & !(load pending or requested & FIFO would exceed MAX_OUT).
- Load push: {rd, byte flag, addr[1:0]} enters the tag FIFO when the command is registered. The FIFO is full at count==MAX_OUT; pointers wrap modulo MAX_OUT.
- Stores: complete on mem_yumi_i and produce no response.
- SB: mem_wdata_o replicates req_wdata_i[7:0] into every byte lane.
- Response handling, on mem_rvalid_i with the FIFO non-empty:
  - pop the FIFO;
  - ld_valid_o=1 the next cycle (latency 1 from mem_rvalid_i);
  - byte loads return ld_data_o = {zeros, mem_rdata_i[8*addr[1:0] +: 8]}; word loads return mem_rdata_i.
- Simultaneous push and pop: count unchanged; a FIFO that is full may push in the same cycle it pops.
- mem_rvalid_i with the FIFO empty: ignored, mem_yumi_o=0, err_o set.
- busy_o = (state!=CMD_IDLE) | (count!=0).
- Reset mid-operation: outstanding tags are discarded and late responses raise err_o. This is acceptable because the network PC packet re-initialises the core.
- err_o clears only on reset.

Optional Feature:
DMEM_MISALIGN_TRAP_EN
- Defined: a word request with addr[1:0]!=0 is accepted (req_ready_o high) but never issued to memory, never pushed to the FIFO, and sets err_o.
- Undefined: word requests force addr[1:0]=0 on mem_addr_o and proceed normally.

Decomposition:
Shared definitions package gains:
- the dmem_cmd_e enum {CMD_IDLE, CMD_SENT}, replacing the dmem_req_state use;
- the packed ld_tag_s {rd, is_byte, byte_sel[1:0]};
- a dmem_max_out_gp parameter default.

Sub-module dmem_tag_fifo (parametrised by width and depth, with count output) holds the tags; the top-level holds the FSM and lane logic.

Test Plan:
- Reset with traffic in flight: assert n_reset low during CMD_SENT with 2 loads queued -> next cycle mem_valid_o=0, busy_o=0, req_ready_o=1; a stray mem_rvalid_i afterwards sets err_o=1.
- LW addr 0x010, rd=3, memory yumi after 2 cycles, rdata 0xDEADBEEF -> mem_valid_o held 2 cycles; ld_valid_o pulse with ld_rd_o=3, ld_data_o=0xDEADBEEF.
- LBU addr 0x013, rd=7, rdata 0xAABBCCDD -> ld_data_o=0x000000AA. SB addr 0x021, wdata 0x12345677 -> mem_wdata_o=0x77777777, mem_byte_o=1.
- Issue 4 loads with no response -> 5th req_ready_o=0; mem_rvalid_i in the same cycle as a 5th req_valid_i -> accepted, count stays 4, results return in issue order (rd 1,2,3,4).
- Back-to-back store then load with mem_yumi_i held 1 -> one command per cycle, FSM stays CMD_SENT, store produces no ld_valid_o.
- LW addr 0x002 -> with DMEM_MISALIGN_TRAP_EN: no mem_valid_o, err_o=1; without: mem_addr_o=0x000.
